// File: rtl/maze_pkg.sv
// maze_pkg: shared constants, FSM state type and border-forcing helper for the maze loader.
//   MAZE_COLS/MAZE_ROWS/MAZE_BYTES : VRAM geometry (5 bytes per row, 7 rows, 35 bytes)
//   WALL_*                         : bit position of each wall inside a 4-bit cell nibble
//   state_e                        : loader FSM states
//   force_borders()                : ORs the outer maze walls into a wall byte
package maze_pkg;

   localparam int unsigned MAZE_COLS  = 5;
   localparam int unsigned MAZE_ROWS  = 7;
   localparam int unsigned MAZE_BYTES = MAZE_COLS * MAZE_ROWS;
   localparam int unsigned IDX_W      = 6;  // byte index width inside one layout

   // Wall bits within a cell nibble; the odd cell of a byte sits 4 bits higher.
   localparam int unsigned WALL_TOP    = 0;
   localparam int unsigned WALL_LEFT   = 1;
   localparam int unsigned WALL_BOTTOM = 2;
   localparam int unsigned WALL_RIGHT  = 3;
   localparam int unsigned NIBBLE      = 4;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StWrite,
      StDone
   } state_e;

   // Top row closes both tops, bottom row both bottoms; only the outermost cell of a
   // byte touches a side border (even cell on the left, odd cell on the right).
   function automatic logic [7:0] force_borders(input logic [7:0] data, input logic [7:0] addr);
      int unsigned a;
      int unsigned row;
      int unsigned col;
      logic [7:0]  d;
      a   = 32'(addr);
      row = a / MAZE_COLS;
      col = a % MAZE_COLS;
      d   = data;
      if (row == 0) begin
         d[WALL_TOP]          = 1'b1;
         d[WALL_TOP + NIBBLE] = 1'b1;
      end
      if (row == MAZE_ROWS - 1) begin
         d[WALL_BOTTOM]          = 1'b1;
         d[WALL_BOTTOM + NIBBLE] = 1'b1;
      end
      if (col == 0) d[WALL_LEFT] = 1'b1;
      if (col == MAZE_COLS - 1) d[WALL_RIGHT + NIBBLE] = 1'b1;
      return d;
   endfunction

endpackage

// File: rtl/maze_rom.sv
// maze_rom: synchronous-read layout store, NUM_MAZES layouts of MAZE_BYTES wall bytes each.
//   clk_i   : clock
//   addr_i  : {layout index, byte index}
//   rdata_o : registered wall byte, valid one cycle after addr_i
// Layout 0 is an open (all-zero) maze; the others are fixed pseudo-random wall patterns.
module maze_rom
   import maze_pkg::*;
#(
   parameter int unsigned NUM_MAZES = 4
) (
   input  logic                                 clk_i,
   input  logic [$clog2(NUM_MAZES)+IDX_W-1:0]   addr_i,
   output logic [7:0]                           rdata_o
);

   localparam int unsigned IdW = $clog2(NUM_MAZES);

   function automatic logic [7:0] layout_byte(input int unsigned m, input int unsigned i);
      int unsigned v;
      if (m == 0 || i >= MAZE_BYTES) return 8'h00;
      v = (i * 29 + m * 53) ^ (m * 17);
      return v[7:0];
   endfunction

   always_ff @(posedge clk_i) begin
      rdata_o <= layout_byte(32'(addr_i[IdW+IDX_W-1:IDX_W]), 32'(addr_i[IDX_W-1:0]));
   end

endmodule

// File: rtl/maze_loader.sv
// maze_loader: copies one stored maze layout into wall VRAM, one byte per cycle, with the
// outer border walls forced on.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   start        : load request (only honoured while idle)
//   maze_sel     : layout to load
//   WALLS_DATA/WALLS_ADDR/WALLS_WE : VRAM write port (addresses 0..34)
//   busy         : high from the start edge until the last byte is written
//   done         : one-cycle pulse after the last byte
//   maze_id      : layout of the current / last load
// Build option: define MAZE_LOADER_LFSR_EN to pick the layout from a free-running 8-bit
// LFSR instead of maze_sel.
module maze_loader
   import maze_pkg::*;
#(
   parameter int unsigned NUM_MAZES = 4
) (
   input  logic                         Clk,
   input  logic                         Reset_n,
   input  logic                         start,
   input  logic [$clog2(NUM_MAZES)-1:0] maze_sel,
   output logic [7:0]                   WALLS_DATA,
   output logic [7:0]                   WALLS_ADDR,
   output logic                         WALLS_WE,
   output logic                         busy,
   output logic                         done,
   output logic [$clog2(NUM_MAZES)-1:0] maze_id
);

   localparam int unsigned      IdW      = $clog2(NUM_MAZES);
   localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(MAZE_BYTES - 1);
   localparam logic [7:0]       LastAddr = 8'(MAZE_BYTES - 1);

   state_e           state_q;
   logic [IDX_W-1:0] cnt_q;   // ROM read index, runs one byte ahead of addr_q
   logic [7:0]       addr_q;
   logic             we_q;
   logic             busy_q;
   logic             done_q;
   logic [IdW-1:0]   id_q;
   logic [7:0]       data_q;  // last byte written, held while idle
   logic [7:0]       rom_data;
   logic [IdW-1:0]   id_src;

`ifdef MAZE_LOADER_LFSR_EN
   logic [7:0] lfsr_q;
   logic       unused_sel;

   // Fibonacci LFSR, taps 8,6,5,4.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) lfsr_q <= 8'h01;
      else          lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   assign id_src     = lfsr_q[IdW-1:0];
   assign unused_sel = ^maze_sel;
`else
   assign id_src = maze_sel;
`endif

   maze_rom #(
      .NUM_MAZES(NUM_MAZES)
   ) u_rom (
      .clk_i  (Clk),
      .addr_i ({id_q, cnt_q}),
      .rdata_o(rom_data)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         id_q    <= '0;
         data_q  <= '0;
      end else begin
         if (we_q) data_q <= WALLS_DATA;
         case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StFetch;
                  id_q    <= id_src;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            StFetch: begin
               // ROM returns byte 0 at this edge, so the first write is already valid.
               state_q <= StWrite;
               we_q    <= 1'b1;
               addr_q  <= '0;
               cnt_q   <= cnt_q + 1'b1;
            end
            StWrite: begin
               if (cnt_q != LastIdx) cnt_q <= cnt_q + 1'b1;
               if (addr_q == LastAddr) begin
                  state_q <= StDone;
                  we_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  addr_q <= addr_q + 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               done_q  <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Borders are applied on the ROM output register; outside a write the last byte holds.
   assign WALLS_DATA = we_q ? force_borders(rom_data, addr_q) : data_q;
   assign WALLS_ADDR = addr_q;
   assign WALLS_WE   = we_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign maze_id    = id_q;

endmodule

// File: tb/tb_maze_loader.sv
// tb_maze_loader: directed + randomized bench for maze_loader with a behavioural VRAM model.
module tb_maze_loader;

   logic       Clk;
   logic       Reset_n;
   logic       start;
   logic [1:0] maze_sel;
   logic [7:0] WALLS_DATA;
   logic [7:0] WALLS_ADDR;
   logic       WALLS_WE;
   logic       busy;
   logic       done;
   logic [1:0] maze_id;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] wa_q[$];
   logic [7:0] wd_q[$];

   maze_loader #(
      .NUM_MAZES(4)
   ) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .start     (start),
      .maze_sel  (maze_sel),
      .WALLS_DATA(WALLS_DATA),
      .WALLS_ADDR(WALLS_ADDR),
      .WALLS_WE  (WALLS_WE),
      .busy      (busy),
      .done      (done),
      .maze_id   (maze_id)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "timeout");
   end

`ifdef MAZE_LOADER_LFSR_EN
   logic [7:0] lfsr_m;

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) lfsr_m <= 8'h01;
      else          lfsr_m <= lfsr_step(lfsr_m);
   end
`endif

   // Layout the load should use, given the value the next edge will sample.
   function automatic logic [1:0] pick_id(input logic [1:0] sel);
`ifdef MAZE_LOADER_LFSR_EN
      return lfsr_m[1:0];
`else
      return sel;
`endif
   endfunction

   // VRAM image of layout m at byte a: stored pattern plus the closed outer walls.
   function automatic logic [7:0] exp_byte(input int m, input int a);
      int v;
      int row;
      int col;
      v   = (m == 0) ? 0 : (((a * 29) + (m * 53)) ^ (m * 17)) & 255;
      row = a / 5;
      col = a % 5;
      if (row == 0) v = v | 'h11;
      if (row == 6) v = v | 'h44;
      if (col == 0) v = v | 'h02;
      if (col == 4) v = v | 'h80;
      return 8'(v);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_we"}, 32'(WALLS_WE), 0);
      check({tag, "_addr"}, 32'(WALLS_ADDR), 0);
      check({tag, "_data"}, 32'(WALLS_DATA), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_id"}, 32'(maze_id), 0);
   endtask

   // One load: pulse (or hold) start, record every write, optionally re-pulse start at
   // pulse_cyc or assert reset at rst_cyc (cycle 1 = FETCH, cycle k+2 = write k).
   task automatic do_load(input logic [1:0] sel, input bit hold, input int pulse_cyc,
                          input int rst_cyc, input string tag);
      logic [1:0] id1;
      logic [1:0] id2;
      int         cyc;
      int         first_we;
      int         done1;
      int         done2;
      int         nw;
      wa_q.delete();
      wd_q.delete();
      maze_sel = sel;
      start    = 1'b1;
      id1      = pick_id(sel);
      id2      = id1;
      @(posedge Clk);
      #1;
      if (!hold) start = 1'b0;
      first_we = -1;
      done1    = -1;
      done2    = -1;
      for (cyc = 1; cyc < 120; cyc++) begin
         if (cyc == 1) begin
            check({tag, "_fetch_busy"}, 32'(busy), 1);
            check({tag, "_fetch_we"}, 32'(WALLS_WE), 0);
         end
         if (WALLS_WE) begin
            if (first_we < 0) first_we = cyc;
            wa_q.push_back(WALLS_ADDR);
            wd_q.push_back(WALLS_DATA);
         end
         if (done) begin
            check({tag, "_done_busy"}, 32'(busy), 0);
            check({tag, "_done_we"}, 32'(WALLS_WE), 0);
            if (done1 < 0) done1 = cyc;
            else           done2 = cyc;
         end
         if (hold && cyc == 38) begin
            check({tag, "_gap_busy"}, 32'(busy), 0);
            id2 = pick_id(sel);
         end
         if (hold && cyc == 39) check({tag, "_refetch_busy"}, 32'(busy), 1);
         if (cyc == pulse_cyc) begin
            start    = 1'b1;
            maze_sel = ~sel;
         end
         if (cyc == pulse_cyc + 1) begin
            start    = 1'b0;
            maze_sel = sel;
         end
         if (cyc == rst_cyc) break;
         if ((!hold && done1 > 0) || done2 > 0) break;
         @(posedge Clk);
         #1;
      end
      nw = wa_q.size();
      if (rst_cyc > 0) begin
         Reset_n = 1'b0;
         #1;
         check_reset_outputs({tag, "_abort"});
         check({tag, "_nwrites"}, 32'(nw), 32'(rst_cyc - 1));
         if (nw > 0) check({tag, "_last_addr"}, 32'(wa_q[nw-1]), 32'(rst_cyc - 2));
         #3;
         Reset_n = 1'b1;
         repeat (3) begin
            @(posedge Clk);
            #1;
            check({tag, "_no_write"}, 32'(WALLS_WE), 0);
         end
         return;
      end
      check({tag, "_first_we"}, 32'(first_we), 2);
      check({tag, "_done_cyc"}, 32'(done1), 37);
      if (hold) check({tag, "_done2_cyc"}, 32'(done2), 75);
      check({tag, "_nwrites"}, 32'(nw), hold ? 70 : 35);
      check({tag, "_maze_id"}, 32'(maze_id), 32'(hold ? id2 : id1));
      for (int i = 0; i < nw; i++) begin
         int m;
         m = (i < 35) ? int'(id1) : int'(id2);
         check({tag, "_addr"}, 32'(wa_q[i]), 32'(i % 35));
         check({tag, "_data"}, 32'(wd_q[i]), 32'(exp_byte(m, i % 35)));
      end
      check({tag, "_hold_addr"}, 32'(WALLS_ADDR), 34);
      check({tag, "_hold_data"}, 32'(WALLS_DATA), 32'(exp_byte(int'(hold ? id2 : id1), 34)));
      start = 1'b0;
      @(posedge Clk);
      #1;
      check({tag, "_pulse_end"}, 32'(done), 0);
      check({tag, "_idle_we"}, 32'(WALLS_WE), 0);
      check({tag, "_idle_data"}, 32'(WALLS_DATA), 32'(exp_byte(int'(hold ? id2 : id1), 34)));
   endtask

   initial begin
      Reset_n  = 1'b0;
      start    = 1'b0;
      maze_sel = 2'd0;
      #2;
      check_reset_outputs("reset");
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;

`ifdef MAZE_LOADER_LFSR_EN
      begin
         logic [7:0] v;
         v = 8'h01;
         for (int k = 0; k < 4; k++) v = lfsr_step(v);
         repeat (4) @(posedge Clk);
         #1;
         do_load(~v[1:0], 1'b0, -1, -1, "lfsr");
         check("lfsr_id", 32'(maze_id), 32'(v[1:0]));
      end
`else
      @(posedge Clk);
      #1;
      do_load(2'd2, 1'b0, -1, -1, "sel2");
      do_load(2'd0, 1'b0, -1, -1, "open");
      check("open_b0", 32'(wd_q[0]), 'h13);
      check("open_b4", 32'(wd_q[4]), 'h91);
      check("open_b30", 32'(wd_q[30]), 'h46);
      check("open_b34", 32'(wd_q[34]), 'hC4);
      check("open_b17", 32'(wd_q[17]), 'h00);
`endif

      do_load(2'd3, 1'b0, 12, -1, "repulse");
      do_load(2'd1, 1'b0, -1, 22, "midreset");
      do_load(2'($urandom_range(0, 3)), 1'b0, -1, -1, "after_rst");
      do_load(2'($urandom_range(0, 3)), 1'b1, -1, -1, "held");
      for (int n = 0; n < 3; n++) begin
         repeat ($urandom_range(0, 3)) @(posedge Clk);
         #1;
         do_load(2'($urandom_range(0, 3)), 1'b0, -1, -1, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
